d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop.sv | 36 +++
 tb/tb_d_flip_flop.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
// d_flip_flop: parameterised D-type register cell with an optional delay
// pipeline. Data moves bit-exact from d to q through STAGES registers, all of
// which are forced to RESET_VALUE asynchronously while resetn is high.
// Note that resetn is active-high despite its name: 1 resets, 0 runs.

module d_flip_flop #(
  parameter int unsigned           WIDTH       = 1,
  parameter int unsigned           STAGES      = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // s[0] is the capture register, s[STAGES-1] drives q directly.
  logic [WIDTH-1:0] s [STAGES];

  // Shift d into the pipeline on every rising edge; reset wipes every stage at once.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        s[i] <= RESET_VALUE;
      end
    end else begin
      s[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        s[i] <= s[i-1];
      end
    end
  end

  assign q = s[STAGES-1];

endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: directed check of the d_flip_flop cell. One instance uses the
// default parameters (single 1-bit stage), the other a 3-deep 8-bit pipeline
// with reset value 8'hA5. Inputs change on an absolute time schedule against
// a 20-unit clock whose rising edges fall at 10, 30, 50, ...

module tb_d_flip_flop;

  logic       clk;
  logic       rst1;
  logic       d1;
  logic       q1;
  logic       rst3;
  logic [7:0] d3;
  logic [7:0] q3;

  int vectors;
  int miscompares;

  d_flip_flop dut1 (
    .clk    (clk),
    .resetn (rst1),
    .d      (d1),
    .q      (q1)
  );

  d_flip_flop #(
    .WIDTH       (8),
    .STAGES      (3),
    .RESET_VALUE (8'hA5)
  ) dut3 (
    .clk    (clk),
    .resetn (rst3),
    .d      (d3),
    .q      (q3)
  );

  // Free-running clock, rising edges at 10, 30, 50, ...
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Advance to an absolute simulation time.
  task automatic waitUntil(input int t);
    if (longint'(t) > longint'($time)) #(longint'(t) - longint'($time));
  endtask

  // Compare one observed output against its hand-computed value.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Directed schedule: single-stage instance first, then the 3-stage pipeline.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst1 = 1'b1;
    d1   = 1'b1;
    rst3 = 1'b1;
    d3   = 8'h00;

    waitUntil(5);
    checkOutput("reset_q1", {7'b0, q1}, 8'h00);
    checkOutput("reset_q3", q3, 8'hA5);

    waitUntil(11);
    checkOutput("edge_in_reset", {7'b0, q1}, 8'h00);

    waitUntil(12);
    rst1 = 1'b0;
    d1   = 1'b0;
    waitUntil(14);
    checkOutput("after_release", {7'b0, q1}, 8'h00);

    waitUntil(15);
    d1 = 1'b1;
    waitUntil(23);
    d1 = 1'b0;
    waitUntil(24);
    checkOutput("glitch_low_hidden", {7'b0, q1}, 8'h00);
    waitUntil(25);
    d1 = 1'b1;
    waitUntil(26);
    checkOutput("glitch_high_hidden", {7'b0, q1}, 8'h00);

    waitUntil(31);
    checkOutput("capture_one_t30", {7'b0, q1}, 8'h01);

    waitUntil(35);
    d1 = 1'b0;
    waitUntil(36);
    checkOutput("hold_between_edges", {7'b0, q1}, 8'h01);

    waitUntil(37);
    rst1 = 1'b1;
    waitUntil(38);
    checkOutput("async_reset_midcycle", {7'b0, q1}, 8'h00);

    waitUntil(45);
    rst1 = 1'b0;
    waitUntil(46);
    checkOutput("released_no_edge", {7'b0, q1}, 8'h00);
    d1 = 1'b1;
    waitUntil(49);
    checkOutput("before_first_capture", {7'b0, q1}, 8'h00);
    waitUntil(51);
    checkOutput("first_capture_t50", {7'b0, q1}, 8'h01);

    waitUntil(55);
    d1 = 1'b0;
    waitUntil(60);
    d1 = 1'b1;
    waitUntil(62);
    d1 = 1'b0;
    waitUntil(65);
    checkOutput("glitch_hidden_2", {7'b0, q1}, 8'h01);
    waitUntil(71);
    checkOutput("capture_zero_t70", {7'b0, q1}, 8'h00);

    waitUntil(75);
    rst1 = 1'b1;
    d1   = 1'b1;
    waitUntil(91);
    checkOutput("reset_hold_t90", {7'b0, q1}, 8'h00);
    waitUntil(111);
    checkOutput("reset_hold_t110", {7'b0, q1}, 8'h00);
    waitUntil(115);
    rst1 = 1'b0;
    waitUntil(131);
    checkOutput("capture_after_hold", {7'b0, q1}, 8'h01);

    // Three-stage pipeline: values appear on the third capture edge.
    waitUntil(142);
    rst3 = 1'b0;
    d3   = 8'h01;
    waitUntil(151);
    checkOutput("pipe_t150", q3, 8'hA5);
    waitUntil(152);
    d3 = 8'h02;
    waitUntil(171);
    checkOutput("pipe_t170", q3, 8'hA5);
    waitUntil(172);
    d3 = 8'h03;
    waitUntil(191);
    checkOutput("pipe_t190", q3, 8'h01);
    waitUntil(192);
    d3 = 8'h04;
    waitUntil(211);
    checkOutput("pipe_t210", q3, 8'h02);
    waitUntil(212);
    d3 = 8'h05;
    waitUntil(231);
    checkOutput("pipe_t230", q3, 8'h03);

    // Two captures in flight, then reset discards them.
    waitUntil(232);
    d3 = 8'hAA;
    waitUntil(252);
    d3 = 8'hBB;
    waitUntil(275);
    rst3 = 1'b1;
    waitUntil(276);
    checkOutput("pipe_async_reset", q3, 8'hA5);
    waitUntil(282);
    rst3 = 1'b0;
    d3   = 8'hCC;
    waitUntil(291);
    checkOutput("flush_t290", q3, 8'hA5);
    waitUntil(311);
    checkOutput("flush_t310", q3, 8'hA5);
    waitUntil(331);
    checkOutput("refill_t330", q3, 8'hCC);
    waitUntil(351);
    checkOutput("refill_t350", q3, 8'hCC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
